// File: rtl/dispatcher_pkg.sv
// Shared constants for the issue stage: internal opcodes (also used by RS, LSB and ALU),
// RISC-V major opcodes, tag/count widths and the renamed-operand record.
package dispatcher_pkg;

    localparam int ROB_ID_W = 4;
    localparam int OP_W     = 6;
    localparam int CNT_W    = 5;

    localparam logic [6:0] RV_LUI    = 7'b0110111;
    localparam logic [6:0] RV_AUIPC  = 7'b0010111;
    localparam logic [6:0] RV_JAL    = 7'b1101111;
    localparam logic [6:0] RV_JALR   = 7'b1100111;
    localparam logic [6:0] RV_BRANCH = 7'b1100011;
    localparam logic [6:0] RV_LOAD   = 7'b0000011;
    localparam logic [6:0] RV_STORE  = 7'b0100011;
    localparam logic [6:0] RV_OPIMM  = 7'b0010011;
    localparam logic [6:0] RV_OP     = 7'b0110011;

    localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
    localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
    localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
    localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
    localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
    localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
    localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
    localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
    localparam logic [OP_W-1:0] OP_LB    = 6'd11;
    localparam logic [OP_W-1:0] OP_LH    = 6'd12;
    localparam logic [OP_W-1:0] OP_LW    = 6'd13;
    localparam logic [OP_W-1:0] OP_LBU   = 6'd14;
    localparam logic [OP_W-1:0] OP_LHU   = 6'd15;
    localparam logic [OP_W-1:0] OP_SB    = 6'd16;
    localparam logic [OP_W-1:0] OP_SH    = 6'd17;
    localparam logic [OP_W-1:0] OP_SW    = 6'd18;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd20;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'd21;
    localparam logic [OP_W-1:0] OP_XORI  = 6'd22;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd23;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd24;
    localparam logic [OP_W-1:0] OP_SLLI  = 6'd25;
    localparam logic [OP_W-1:0] OP_SRLI  = 6'd26;
    localparam logic [OP_W-1:0] OP_SRAI  = 6'd27;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd28;
    localparam logic [OP_W-1:0] OP_SUB   = 6'd29;
    localparam logic [OP_W-1:0] OP_SLL   = 6'd30;
    localparam logic [OP_W-1:0] OP_SLT   = 6'd31;
    localparam logic [OP_W-1:0] OP_SLTU  = 6'd32;
    localparam logic [OP_W-1:0] OP_XOR   = 6'd33;
    localparam logic [OP_W-1:0] OP_SRL   = 6'd34;
    localparam logic [OP_W-1:0] OP_SRA   = 6'd35;
    localparam logic [OP_W-1:0] OP_OR    = 6'd36;
    localparam logic [OP_W-1:0] OP_AND   = 6'd37;

    // r=1: v holds the value and q is 0; r=0: waiting on ROB tag q.
    typedef struct packed {
        logic                r;
        logic [ROB_ID_W-1:0] q;
        logic [31:0]         v;
    } operand_t;

endpackage

// File: rtl/dispatcher_decoder.sv
// Combinational RV32I decoder. Unknown encodings map to OP_NOP with no sources and no rd,
// so they flow to the RS as harmless placeholders.
module dispatcher_decoder
    import dispatcher_pkg::*;
(
    input  logic [31:0]     inst,
    output logic [OP_W-1:0] opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            use1,
    output logic            use2,
    output logic [31:0]     imm,
    output logic            is_mem,
    output logic            writes_rd
);
    logic [6:0]  major;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign major = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign rs1   = inst[19:15];
    assign rs2   = inst[24:20];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        opcode    = OP_NOP;
        use1      = 1'b0;
        use2      = 1'b0;
        imm       = '0;
        is_mem    = 1'b0;
        writes_rd = 1'b0;
        unique case (major)
            RV_LUI:   begin opcode = OP_LUI;   imm = imm_u; writes_rd = 1'b1; end
            RV_AUIPC: begin opcode = OP_AUIPC; imm = imm_u; writes_rd = 1'b1; end
            RV_JAL:   begin opcode = OP_JAL;   imm = imm_j; writes_rd = 1'b1; end
            RV_JALR: if (f3 == 3'b000) begin
                opcode = OP_JALR; imm = imm_i; use1 = 1'b1; writes_rd = 1'b1;
            end
            RV_BRANCH: begin
                case (f3)
                    3'b000:  opcode = OP_BEQ;
                    3'b001:  opcode = OP_BNE;
                    3'b100:  opcode = OP_BLT;
                    3'b101:  opcode = OP_BGE;
                    3'b110:  opcode = OP_BLTU;
                    3'b111:  opcode = OP_BGEU;
                    default: opcode = OP_NOP;
                endcase
                if (opcode != OP_NOP) begin imm = imm_b; use1 = 1'b1; use2 = 1'b1; end
            end
            RV_LOAD: begin
                case (f3)
                    3'b000:  opcode = OP_LB;
                    3'b001:  opcode = OP_LH;
                    3'b010:  opcode = OP_LW;
                    3'b100:  opcode = OP_LBU;
                    3'b101:  opcode = OP_LHU;
                    default: opcode = OP_NOP;
                endcase
                if (opcode != OP_NOP) begin
                    imm = imm_i; use1 = 1'b1; is_mem = 1'b1; writes_rd = 1'b1;
                end
            end
            RV_STORE: begin
                case (f3)
                    3'b000:  opcode = OP_SB;
                    3'b001:  opcode = OP_SH;
                    3'b010:  opcode = OP_SW;
                    default: opcode = OP_NOP;
                endcase
                if (opcode != OP_NOP) begin
                    imm = imm_s; use1 = 1'b1; use2 = 1'b1; is_mem = 1'b1;
                end
            end
            RV_OPIMM: begin
                case (f3)
                    3'b000:  opcode = OP_ADDI;
                    3'b010:  opcode = OP_SLTI;
                    3'b011:  opcode = OP_SLTIU;
                    3'b100:  opcode = OP_XORI;
                    3'b110:  opcode = OP_ORI;
                    3'b111:  opcode = OP_ANDI;
                    3'b001:  opcode = (f7 == 7'h00) ? OP_SLLI : OP_NOP;
                    default: opcode = (f7 == 7'h00) ? OP_SRLI : (f7 == 7'h20) ? OP_SRAI : OP_NOP;
                endcase
                if (opcode != OP_NOP) begin imm = imm_i; use1 = 1'b1; writes_rd = 1'b1; end
            end
            RV_OP: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  opcode = OP_ADD;
                        3'b001:  opcode = OP_SLL;
                        3'b010:  opcode = OP_SLT;
                        3'b011:  opcode = OP_SLTU;
                        3'b100:  opcode = OP_XOR;
                        3'b101:  opcode = OP_SRL;
                        3'b110:  opcode = OP_OR;
                        default: opcode = OP_AND;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'b000) begin
                    opcode = OP_SUB;
                end else if (f7 == 7'h20 && f3 == 3'b101) begin
                    opcode = OP_SRA;
                end
                if (opcode != OP_NOP) begin use1 = 1'b1; use2 = 1'b1; writes_rd = 1'b1; end
            end
            default: ;
        endcase
    end

    // rd is zeroed when not written so downstream bypass/rename logic can key on rd alone.
    assign rd = writes_rd ? inst[11:7] : 5'd0;

endmodule

// File: rtl/dispatcher.sv
// Issue stage: pops the IQ, decodes, renames both sources against the in-flight stage,
// regfile, live broadcasts and ROB, then presents one registered packet to the RS or LSB.
module dispatcher
    import dispatcher_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                clear,
    input  logic                inst_valid,
    output logic                inst_ready,
    input  logic [31:0]         inst,
    input  logic [31:0]         inst_pc,
    output logic [4:0]          rf_rs1,
    output logic [4:0]          rf_rs2,
    input  logic                rf_busy1,
    input  logic                rf_busy2,
    input  logic [ROB_ID_W-1:0] rf_tag1,
    input  logic [ROB_ID_W-1:0] rf_tag2,
    input  logic [31:0]         rf_val1,
    input  logic [31:0]         rf_val2,
    output logic [ROB_ID_W-1:0] rob_q1_id,
    output logic [ROB_ID_W-1:0] rob_q2_id,
    input  logic                rob_q1_rdy,
    input  logic [31:0]         rob_q1_val,
    input  logic                rob_q2_rdy,
    input  logic [31:0]         rob_q2_val,
    input  logic [ROB_ID_W-1:0] rob_tail_id,
    input  logic [CNT_W-1:0]    rob_free_cnt,
    input  logic [CNT_W-1:0]    rs_free_cnt,
    input  logic [CNT_W-1:0]    lsb_free_cnt,
    input  logic                is_alu_ok,
    input  logic [ROB_ID_W-1:0] rob_id_from_alu,
    input  logic [31:0]         res_from_alu,
    input  logic                is_lsb_ok,
    input  logic [ROB_ID_W-1:0] rob_id_from_lsb,
    input  logic [31:0]         res_from_lsb,
    input  logic                is_rob_ok,
    input  logic [ROB_ID_W-1:0] rob_id_from_rob,
    input  logic [31:0]         res_from_rob,
    output logic                rob_issue,
    output logic [4:0]          rob_rd,
    output logic [31:0]         rob_pc_o,
    output logic                rf_rename_en,
    output logic [4:0]          rf_rename_rd,
    output logic [ROB_ID_W-1:0] rf_rename_tag,
    output logic                is_issue,
    output logic                is_issue_lsb,
    output logic [OP_W-1:0]     issue_opcode,
    output logic [ROB_ID_W-1:0] issue_rob_id,
    output logic [31:0]         issue_Vi,
    output logic [ROB_ID_W-1:0] issue_Qi,
    output logic                issue_Ri,
    output logic [31:0]         issue_Vj,
    output logic [ROB_ID_W-1:0] issue_Qj,
    output logic                issue_Rj,
    output logic [31:0]         issue_imm,
    output logic [31:0]         issue_pc
);
    typedef struct packed {
        logic                v;
        logic                lsb;
        logic [ROB_ID_W-1:0] tag;
        logic [4:0]          rd;
        logic [OP_W-1:0]     opcode;
        logic [31:0]         pc;
        logic [31:0]         imm;
        operand_t            opi;
        operand_t            opj;
    } stage_t;

    stage_t s_q, s_d;

    logic [OP_W-1:0] dec_opcode;
    logic [4:0]      dec_rd, dec_rs1, dec_rs2;
    logic            dec_use1, dec_use2, dec_is_mem, dec_writes_rd;
    logic [31:0]     dec_imm;

    dispatcher_decoder u_decoder (
        .inst      (inst),
        .opcode    (dec_opcode),
        .rd        (dec_rd),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .use1      (dec_use1),
        .use2      (dec_use2),
        .imm       (dec_imm),
        .is_mem    (dec_is_mem),
        .writes_rd (dec_writes_rd)
    );

    assign rf_rs1    = dec_rs1;
    assign rf_rs2    = dec_rs2;
    assign rob_q1_id = rf_tag1;
    assign rob_q2_id = rf_tag2;

    // Slots in S are already spoken for but not yet visible in the free counts.
    logic s_rs, s_lsb, fire;
    logic [ROB_ID_W-1:0] new_tag;
    assign s_lsb   = s_q.v & s_q.lsb;
    assign s_rs    = s_q.v & ~s_q.lsb;
    assign new_tag = rob_tail_id + ROB_ID_W'(s_q.v);

    always_comb begin
        inst_ready = rdy & ~clear & (rob_free_cnt > CNT_W'(s_q.v)) &
                     (dec_is_mem ? (lsb_free_cnt > CNT_W'(s_lsb)) : (rs_free_cnt > CNT_W'(s_rs)));
    end
    assign fire = inst_valid & inst_ready;

    // Broadcast lookup for four tags: the two regfile tags and the two registered Q fields.
    logic [ROB_ID_W-1:0] look_tag [4];
    logic [3:0]          look_hit;
    logic [31:0]         look_val [4];

    assign look_tag[0] = rf_tag1;
    assign look_tag[1] = rf_tag2;
    assign look_tag[2] = s_q.opi.q;
    assign look_tag[3] = s_q.opj.q;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            look_hit[k] = 1'b0;
            look_val[k] = '0;
            if (is_rob_ok && rob_id_from_rob == look_tag[k]) begin
                look_hit[k] = 1'b1; look_val[k] = res_from_rob;
            end
            if (is_lsb_ok && rob_id_from_lsb == look_tag[k]) begin
                look_hit[k] = 1'b1; look_val[k] = res_from_lsb;
            end
            if (is_alu_ok && rob_id_from_alu == look_tag[k]) begin
                look_hit[k] = 1'b1; look_val[k] = res_from_alu;
            end
        end
    end

    function automatic operand_t resolve(
        input logic                use_src,
        input logic [4:0]          src,
        input logic                busy,
        input logic [ROB_ID_W-1:0] tag,
        input logic [31:0]         val,
        input logic                bc_hit,
        input logic [31:0]         bc_val,
        input logic                q_rdy,
        input logic [31:0]         q_val,
        input logic                s_v,
        input logic [4:0]          s_rd,
        input logic [ROB_ID_W-1:0] s_tag
    );
        operand_t o;
        if (!use_src || src == 5'd0)               o = '{r: 1'b1, q: '0,    v: '0};
        else if (s_v && s_rd != 5'd0 && s_rd == src) o = '{r: 1'b0, q: s_tag, v: '0};
        else if (!busy)                            o = '{r: 1'b1, q: '0,    v: val};
        else if (bc_hit)                           o = '{r: 1'b1, q: '0,    v: bc_val};
        else if (q_rdy)                            o = '{r: 1'b1, q: '0,    v: q_val};
        else                                       o = '{r: 1'b0, q: tag,   v: '0};
        return o;
    endfunction

    always_comb begin
        s_d = s_q;
        if (rdy) begin
            s_d.v = fire;
            if (fire) begin
                s_d.lsb    = dec_is_mem;
                s_d.tag    = new_tag;
                s_d.rd     = dec_rd;
                s_d.opcode = dec_opcode;
                s_d.pc     = inst_pc;
                s_d.imm    = dec_imm;
                s_d.opi    = resolve(dec_use1, dec_rs1, rf_busy1, rf_tag1, rf_val1, look_hit[0],
                                     look_val[0], rob_q1_rdy, rob_q1_val, s_q.v, s_q.rd, s_q.tag);
                s_d.opj    = resolve(dec_use2, dec_rs2, rf_busy2, rf_tag2, rf_val2, look_hit[1],
                                     look_val[1], rob_q2_rdy, rob_q2_val, s_q.v, s_q.rd, s_q.tag);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) s_q <= '0;
        else              s_q <= s_d;
    end

    // The RS cannot snoop the entry it is writing, so late broadcasts are folded in here.
    operand_t out_i, out_j;
    always_comb begin
        out_i = s_q.opi;
        out_j = s_q.opj;
        if (s_q.v && !s_q.opi.r && look_hit[2]) out_i = '{r: 1'b1, q: '0, v: look_val[2]};
        if (s_q.v && !s_q.opj.r && look_hit[3]) out_j = '{r: 1'b1, q: '0, v: look_val[3]};
    end

    assign rob_issue     = s_q.v;
    assign rob_rd        = s_q.rd;
    assign rob_pc_o      = s_q.pc;
    assign rf_rename_en  = s_q.v & (s_q.rd != 5'd0);
    assign rf_rename_rd  = s_q.rd;
    assign rf_rename_tag = s_q.tag;
    assign is_issue      = s_rs;
    assign is_issue_lsb  = s_lsb;
    assign issue_opcode  = s_q.opcode;
    assign issue_rob_id  = s_q.tag;
    assign issue_Vi      = out_i.v;
    assign issue_Qi      = out_i.q;
    assign issue_Ri      = out_i.r;
    assign issue_Vj      = out_j.v;
    assign issue_Qj      = out_j.q;
    assign issue_Rj      = out_j.r;
    assign issue_imm     = s_q.imm;
    assign issue_pc      = s_q.pc;

endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for the dispatcher: rename/bypass, broadcast capture and patch, tag wrap,
// back-pressure, rdy hold, clear/reset squash and illegal encodings.
module tb_dispatcher;
    import dispatcher_pkg::*;

    logic                clk = 1'b0;
    logic                rst, rdy, clear, inst_valid, inst_ready;
    logic [31:0]         inst, inst_pc;
    logic [4:0]          rf_rs1, rf_rs2;
    logic                rf_busy1, rf_busy2;
    logic [ROB_ID_W-1:0] rf_tag1, rf_tag2, rob_q1_id, rob_q2_id, rob_tail_id;
    logic [31:0]         rf_val1, rf_val2, rob_q1_val, rob_q2_val;
    logic                rob_q1_rdy, rob_q2_rdy;
    logic [CNT_W-1:0]    rob_free_cnt, rs_free_cnt, lsb_free_cnt;
    logic                is_alu_ok, is_lsb_ok, is_rob_ok;
    logic [ROB_ID_W-1:0] rob_id_from_alu, rob_id_from_lsb, rob_id_from_rob;
    logic [31:0]         res_from_alu, res_from_lsb, res_from_rob;
    logic                rob_issue, rf_rename_en, is_issue, is_issue_lsb;
    logic [4:0]          rob_rd, rf_rename_rd;
    logic [31:0]         rob_pc_o, issue_Vi, issue_Vj, issue_imm, issue_pc;
    logic [ROB_ID_W-1:0] rf_rename_tag, issue_rob_id, issue_Qi, issue_Qj;
    logic [OP_W-1:0]     issue_opcode;
    logic                issue_Ri, issue_Rj;

    int checks = 0;
    int failures = 0;

    dispatcher dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_busy1(rf_busy1), .rf_busy2(rf_busy2), .rf_tag1(rf_tag1), .rf_tag2(rf_tag2),
        .rf_val1(rf_val1), .rf_val2(rf_val2),
        .rob_q1_id(rob_q1_id), .rob_q2_id(rob_q2_id),
        .rob_q1_rdy(rob_q1_rdy), .rob_q1_val(rob_q1_val),
        .rob_q2_rdy(rob_q2_rdy), .rob_q2_val(rob_q2_val),
        .rob_tail_id(rob_tail_id), .rob_free_cnt(rob_free_cnt),
        .rs_free_cnt(rs_free_cnt), .lsb_free_cnt(lsb_free_cnt),
        .is_alu_ok(is_alu_ok), .rob_id_from_alu(rob_id_from_alu), .res_from_alu(res_from_alu),
        .is_lsb_ok(is_lsb_ok), .rob_id_from_lsb(rob_id_from_lsb), .res_from_lsb(res_from_lsb),
        .is_rob_ok(is_rob_ok), .rob_id_from_rob(rob_id_from_rob), .res_from_rob(res_from_rob),
        .rob_issue(rob_issue), .rob_rd(rob_rd), .rob_pc_o(rob_pc_o),
        .rf_rename_en(rf_rename_en), .rf_rename_rd(rf_rename_rd), .rf_rename_tag(rf_rename_tag),
        .is_issue(is_issue), .is_issue_lsb(is_issue_lsb),
        .issue_opcode(issue_opcode), .issue_rob_id(issue_rob_id),
        .issue_Vi(issue_Vi), .issue_Qi(issue_Qi), .issue_Ri(issue_Ri),
        .issue_Vj(issue_Vj), .issue_Qj(issue_Qj), .issue_Rj(issue_Rj),
        .issue_imm(issue_imm), .issue_pc(issue_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; inst_valid = 1'b0; inst = '0; inst_pc = '0;
        rf_busy1 = 1'b0; rf_busy2 = 1'b0; rf_tag1 = '0; rf_tag2 = '0; rf_val1 = '0; rf_val2 = '0;
        rob_q1_rdy = 1'b0; rob_q2_rdy = 1'b0; rob_q1_val = '0; rob_q2_val = '0;
        rob_tail_id = '0; rob_free_cnt = 5'd8; rs_free_cnt = 5'd8; lsb_free_cnt = 5'd8;
        is_alu_ok = 1'b0; is_lsb_ok = 1'b0; is_rob_ok = 1'b0;
        rob_id_from_alu = '0; rob_id_from_lsb = '0; rob_id_from_rob = '0;
        res_from_alu = '0; res_from_lsb = '0; res_from_rob = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state.
        chk("rst_is_issue", {31'b0, is_issue}, 32'd0);
        chk("rst_is_issue_lsb", {31'b0, is_issue_lsb}, 32'd0);
        chk("rst_rob_issue", {31'b0, rob_issue}, 32'd0);
        chk("rst_rename_en", {31'b0, rf_rename_en}, 32'd0);
        chk("rst_rob_id", {28'b0, issue_rob_id}, 32'd0);
        chk("rst_imm", issue_imm, 32'd0);
        chk("rst_inst_ready", {31'b0, inst_ready}, 32'd1);

        // ADDI x1,x0,5 at pc 0, tail 3.
        inst = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011); inst_pc = 32'h0;
        inst_valid = 1'b1; rob_tail_id = 4'd3;
        #1;
        chk("addi_ready", {31'b0, inst_ready}, 32'd1);
        chk("addi_rf_rs1", {27'b0, rf_rs1}, 32'd0);
        tick();
        chk("addi_is_issue", {31'b0, is_issue}, 32'd1);
        chk("addi_is_issue_lsb", {31'b0, is_issue_lsb}, 32'd0);
        chk("addi_rob_id", {28'b0, issue_rob_id}, 32'd3);
        chk("addi_Ri", {31'b0, issue_Ri}, 32'd1);
        chk("addi_Vi", issue_Vi, 32'd0);
        chk("addi_imm", issue_imm, 32'd5);
        chk("addi_opcode", {26'b0, issue_opcode}, {26'b0, OP_ADDI});
        chk("addi_rename_en", {31'b0, rf_rename_en}, 32'd1);
        chk("addi_rename_rd", {27'b0, rf_rename_rd}, 32'd1);
        chk("addi_rename_tag", {28'b0, rf_rename_tag}, 32'd3);
        chk("addi_rob_issue", {31'b0, rob_issue}, 32'd1);
        chk("addi_rob_rd", {27'b0, rob_rd}, 32'd1);

        // ADD x2,x1,x1 back-to-back; regfile still shows x1 free.
        inst = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2); inst_pc = 32'h4;
        rf_tag1 = 4'd2; rf_val1 = 32'hdead; rf_val2 = 32'hbeef;
        #1;
        chk("rob_q1_id", {28'b0, rob_q1_id}, 32'd2);
        tick();
        chk("add_rob_id", {28'b0, issue_rob_id}, 32'd4);
        chk("add_Ri", {31'b0, issue_Ri}, 32'd0);
        chk("add_Rj", {31'b0, issue_Rj}, 32'd0);
        chk("add_Qi", {28'b0, issue_Qi}, 32'd3);
        chk("add_Qj", {28'b0, issue_Qj}, 32'd3);
        chk("add_opcode", {26'b0, issue_opcode}, {26'b0, OP_ADD});
        chk("add_rename_tag", {28'b0, rf_rename_tag}, 32'd4);
        chk("add_pc", issue_pc, 32'h4);

        // ADDI x6,x7,1: x7 busy on tag 7, ALU broadcasts tag 7 in the capture cycle.
        inst = enc_i(12'd1, 5'd7, 3'b000, 5'd6, 7'b0010011); inst_pc = 32'h8;
        rf_busy1 = 1'b1; rf_tag1 = 4'd7; rob_tail_id = 4'd5;
        is_alu_ok = 1'b1; rob_id_from_alu = 4'd7; res_from_alu = 32'h1234;
        tick();
        chk("bc_cap_Ri", {31'b0, issue_Ri}, 32'd1);
        chk("bc_cap_Vi", issue_Vi, 32'h1234);
        chk("bc_cap_Qi", {28'b0, issue_Qi}, 32'd0);
        chk("bc_cap_rob_id", {28'b0, issue_rob_id}, 32'd6);

        // Same instruction, broadcast only in the output cycle.
        is_alu_ok = 1'b0;
        tick();
        chk("bc_out_wait_Ri", {31'b0, issue_Ri}, 32'd0);
        chk("bc_out_wait_Qi", {28'b0, issue_Qi}, 32'd7);
        inst_valid = 1'b0; rf_busy1 = 1'b0;
        is_alu_ok = 1'b1;
        #1;
        chk("bc_out_Ri", {31'b0, issue_Ri}, 32'd1);
        chk("bc_out_Vi", issue_Vi, 32'h1234);
        chk("bc_out_Qi", {28'b0, issue_Qi}, 32'd0);
        tick();
        is_alu_ok = 1'b0;
        chk("drop_is_issue", {31'b0, is_issue}, 32'd0);
        chk("drop_rob_issue", {31'b0, rob_issue}, 32'd0);

        // Tag wrap and ROB back-pressure.
        inst = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011); inst_valid = 1'b1;
        rob_tail_id = 4'd15;
        tick();
        chk("wrap_first_id", {28'b0, issue_rob_id}, 32'd15);
        rob_free_cnt = 5'd1;
        #1;
        chk("robfull_ready", {31'b0, inst_ready}, 32'd0);
        rob_free_cnt = 5'd2;
        #1;
        chk("robfree_ready", {31'b0, inst_ready}, 32'd1);
        tick();
        chk("wrap_id", {28'b0, issue_rob_id}, 32'd0);

        // rdy low holds state and outputs.
        rdy = 1'b0;
        tick();
        chk("hold_is_issue", {31'b0, is_issue}, 32'd1);
        chk("hold_rob_id", {28'b0, issue_rob_id}, 32'd0);
        chk("hold_rob_issue", {31'b0, rob_issue}, 32'd1);
        rdy = 1'b1; rob_free_cnt = 5'd8;

        // LW x3,4(x2): LSB full, then clear in the capture cycle.
        inst = enc_i(12'd4, 5'd2, 3'b010, 5'd3, 7'b0000011); inst_pc = 32'h40;
        rf_val1 = 32'h55; lsb_free_cnt = 5'd0;
        #1;
        chk("lsbfull_ready", {31'b0, inst_ready}, 32'd0);
        lsb_free_cnt = 5'd8; clear = 1'b1;
        #1;
        chk("clear_ready", {31'b0, inst_ready}, 32'd0);
        tick();
        clear = 1'b0;
        chk("clear_is_issue_lsb", {31'b0, is_issue_lsb}, 32'd0);
        chk("clear_is_issue", {31'b0, is_issue}, 32'd0);
        chk("clear_rob_issue", {31'b0, rob_issue}, 32'd0);
        chk("clear_rename_en", {31'b0, rf_rename_en}, 32'd0);
        tick();
        chk("lw_is_issue_lsb", {31'b0, is_issue_lsb}, 32'd1);
        chk("lw_is_issue", {31'b0, is_issue}, 32'd0);
        chk("lw_opcode", {26'b0, issue_opcode}, {26'b0, OP_LW});
        chk("lw_rob_id", {28'b0, issue_rob_id}, 32'd15);
        chk("lw_Vi", issue_Vi, 32'h55);
        chk("lw_imm", issue_imm, 32'd4);
        chk("lw_rename_rd", {27'b0, rf_rename_rd}, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_lw_is_issue_lsb", {31'b0, is_issue_lsb}, 32'd0);
        chk("rst_lw_rob_issue", {31'b0, rob_issue}, 32'd0);
        chk("rst_lw_rename_en", {31'b0, rf_rename_en}, 32'd0);

        // Illegal encoding: RS with OP_NOP, still allocates.
        inst = 32'hffff_ffff; inst_pc = 32'h80;
        tick();
        inst_valid = 1'b0;
        chk("ill_is_issue", {31'b0, is_issue}, 32'd1);
        chk("ill_opcode", {26'b0, issue_opcode}, {26'b0, OP_NOP});
        chk("ill_rob_issue", {31'b0, rob_issue}, 32'd1);
        chk("ill_rename_en", {31'b0, rf_rename_en}, 32'd0);
        chk("ill_rob_id", {28'b0, issue_rob_id}, 32'd15);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
